board_tx_formatter: RTL

- Upstream neighbour of the UART transmitter. On a start request it snapshots the 3x3 tic-tac-toe board and renders it as ASCII text, for example "X|.|O" followed by CR LF per row.
- It feeds that text to the transmitter one byte at a time, using the transmitter's valid/active/done handshake.
- It sits between game control logic and the UART TX, so the board can be printed on a host terminal after every move.

---
 rtl/board_tx_formatter_if.sv | 23 ++
 rtl/board_tx_formatter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/board_tx_formatter_if.sv
// Byte-stream handshake between the board formatter and the UART transmitter.
// The formatter is the master: it requests one byte at a time and the
// transmitter reports acceptance (tx_active) and completion (tx_done).
interface board_tx_formatter_if;
    logic       tx_data_valid;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;

    modport master (
        output tx_data_valid,
        output tx_byte,
        input  tx_active,
        input  tx_done
    );

    modport slave (
        input  tx_data_valid,
        input  tx_byte,
        output tx_active,
        output tx_done
    );
endinterface

// File: rtl/board_tx_formatter.sv
// Tic-tac-toe board to ASCII text formatter.
// On start the 3x3 board is snapshotted and rendered row by row as
// "c|c|c" plus a line ending, one byte per UART transmission.
// A row counter and a column position walk through the frame alongside
// byte_idx so the character can be chosen without dividing by the row length.
module board_tx_formatter #(
    parameter bit         NEWLINE_CRLF = 1'b1,
    parameter logic [7:0] EMPTY_CHAR   = 8'h2E
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [17:0]           board,
    output logic                  busy,
    output logic                  frame_done,
    board_tx_formatter_if.master  tx
);

    localparam int         ROW_LEN   = NEWLINE_CRLF ? 7 : 6;
    localparam int         FRAME_LEN = 3 * ROW_LEN;
    localparam logic [4:0] LAST_IDX  = 5'(FRAME_LEN - 1);
    localparam logic [2:0] LAST_COL  = 3'(ROW_LEN - 1);

    localparam logic [7:0] CHAR_X    = 8'h58;
    localparam logic [7:0] CHAR_O    = 8'h4F;
    localparam logic [7:0] CHAR_BAD  = 8'h3F;
    localparam logic [7:0] CHAR_BAR  = 8'h7C;
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_FINISH
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  byte_idx_q, byte_idx_d;
    logic [1:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic [17:0] snap_q, snap_d;
    logic        valid_q, valid_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    logic [3:0]  cell_idx;
    logic [1:0]  cell_code;
    logic [7:0]  next_char;

    // Map a 2-bit cell code to its printable character.
    function automatic logic [7:0] cell_ascii(input logic [1:0] code);
        logic [7:0] ch;
        unique case (code)
            2'b00:   ch = EMPTY_CHAR;
            2'b01:   ch = CHAR_X;
            2'b10:   ch = CHAR_O;
            default: ch = CHAR_BAD;
        endcase
        return ch;
    endfunction

    // Sequence the frame: accept start, request a byte, wait for the
    // transmitter to take it and finish it, then step to the next byte.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        row_d      = row_q;
        col_d      = col_q;
        snap_d     = snap_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d     = board;
                    byte_idx_d = 5'd0;
                    row_d      = 2'd0;
                    col_d      = 3'd0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx.tx_active) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx.tx_done) begin
                    if (byte_idx_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        byte_idx_d = byte_idx_q + 5'd1;
                        if (col_q == LAST_COL) begin
                            col_d = 3'd0;
                            row_d = row_q + 2'd1;
                        end else begin
                            col_d = col_q + 3'd1;
                        end
                        state_d = ST_SEND;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pick the character for the upcoming byte from the row and column
    // it will occupy; even columns 0/2/4 are cells, 1/3 are separators.
    always_comb begin
        cell_idx  = {2'b00, row_d} + {1'b0, row_d, 1'b0} + {2'b00, col_d[2:1]};
        cell_code = snap_d[{cell_idx, 1'b0} +: 2];
        next_char = CHAR_LF;
        unique case (col_d)
            3'd0, 3'd2, 3'd4: next_char = cell_ascii(cell_code);
            3'd1, 3'd3:       next_char = CHAR_BAR;
            3'd5:             next_char = NEWLINE_CRLF ? CHAR_CR : CHAR_LF;
            default:          next_char = CHAR_LF;
        endcase
    end

    // Registered outputs follow the state being entered, so the byte and its
    // valid strobe appear together and the byte holds until the next request.
    always_comb begin
        valid_d      = (state_d == ST_SEND);
        busy_d       = (state_d == ST_SEND) || (state_d == ST_WAIT_ACK) ||
                       (state_d == ST_WAIT_DONE);
        frame_done_d = (state_d == ST_FINISH);
        tx_byte_d    = (state_d == ST_SEND) ? next_char : tx_byte_q;
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            byte_idx_q   <= 5'd0;
            row_q        <= 2'd0;
            col_q        <= 3'd0;
            snap_q       <= 18'd0;
            valid_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            snap_q       <= snap_d;
            valid_q      <= valid_d;
            tx_byte_q    <= tx_byte_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx.tx_data_valid = valid_q;
    assign tx.tx_byte       = tx_byte_q;
    assign busy             = busy_q;
    assign frame_done       = frame_done_q;

endmodule
